// File: rtl/fetch_pkg.sv
// Shared types for the instruction-fetch front end.
package fetch_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FETCH  = 2'd1,
      DRAIN  = 2'd2,
      HALTED = 2'd3
   } state_t;

   localparam int PC_STEP = 4;

   typedef struct packed {
      logic [31:0] pc;
      logic [31:0] instr;
   } entry_t;

endpackage

// File: rtl/fetch_sequencer_if.sv
// Instruction-memory read port plus the fetch-to-decode valid/ready handshake.
interface fetch_sequencer_if #(
   parameter int ADDR_WIDTH = 6
);
   logic [ADDR_WIDTH+1:0] imem_addr;
   logic [31:0]           imem_rdata;
   logic                  if_valid;
   logic                  if_ready;
   logic [31:0]           if_instr;
   logic [31:0]           if_pc;

   modport master (
      output imem_addr,
      input  imem_rdata,
      output if_valid,
      input  if_ready,
      output if_instr,
      output if_pc
   );

   modport slave (
      input  imem_addr,
      output imem_rdata,
      input  if_valid,
      output if_ready,
      input  if_instr,
      input  if_pc
   );
endinterface

// File: rtl/fetch_buffer.sv
// Small FIFO of {pc, instr} entries; flush beats push, and push+pop while full is legal.
module fetch_buffer
   import fetch_pkg::*;
#(
   parameter int DEPTH = 2,
   parameter int CNT_W = $clog2(DEPTH) + 1
) (
   input  logic             clock,
   input  logic             resetn,
   input  logic             i_push,
   input  logic             i_pop,
   input  logic             i_flush,
   input  entry_t           i_wr_data,
   output entry_t           o_head,
   output logic [CNT_W-1:0] o_count,
   output logic             o_full,
   output logic             o_empty
);
   localparam int PTR_W = $clog2(DEPTH);

   entry_t           r_mem [DEPTH];
   entry_t           r_hold;
   logic [PTR_W-1:0] r_wr_ptr;
   logic [PTR_W-1:0] r_rd_ptr;
   logic [CNT_W-1:0] r_count;

   logic w_do_pop;
   logic w_do_push;

   assign o_empty   = (r_count == '0);
   assign o_full    = (r_count == CNT_W'(DEPTH));
   assign o_count   = r_count;
   assign w_do_pop  = i_pop && !o_empty;
   assign w_do_push = i_push && !i_flush && (!o_full || w_do_pop);

   // When empty, the last presented head is held so decode never sees stale slots.
   assign o_head = o_empty ? r_hold : r_mem[r_rd_ptr];

   always_ff @(posedge clock) begin
      if (w_do_push)
         r_mem[r_wr_ptr] <= i_wr_data;
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_hold   <= '0;
      end else begin
         if (!o_empty)
            r_hold <= r_mem[r_rd_ptr];
         if (i_flush) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
         end else begin
            if (w_do_push)
               r_wr_ptr <= r_wr_ptr + PTR_W'(1);
            if (w_do_pop)
               r_rd_ptr <= r_rd_ptr + PTR_W'(1);
            case ({w_do_push, w_do_pop})
               2'b10:   r_count <= r_count + CNT_W'(1);
               2'b01:   r_count <= r_count - CNT_W'(1);
               default: r_count <= r_count;
            endcase
         end
      end
   end
endmodule

// File: rtl/fetch_sequencer.sv
// Fetch controller: owns the PC, sequences start/halt, and flushes on redirects.
module fetch_sequencer
   import fetch_pkg::*;
#(
   parameter int          ADDR_WIDTH = 6,
   parameter logic [31:0] RESET_PC   = 32'd0,
   parameter int          BUF_DEPTH  = 2
) (
   input  logic              clock,
   input  logic              resetn,
   input  logic              i_start,
   input  logic              i_halt_req,
   input  logic              i_redirect_valid,
   input  logic [31:0]       i_redirect_pc,
   output logic              o_busy,
   output logic [1:0]        o_state,
   fetch_sequencer_if.master bus
);
   localparam int PC_W  = ADDR_WIDTH + 2;
   localparam int CNT_W = $clog2(BUF_DEPTH) + 1;

   state_t           r_state;
   state_t           w_state_next;
   logic [PC_W-1:0]  r_pc;
   logic [PC_W-1:0]  w_pc_next;

   entry_t           w_wr_entry;
   entry_t           w_head;
   logic [CNT_W-1:0] w_count;
   logic             w_full;
   logic             w_empty;
   logic             w_pop;
   logic             w_push;
   logic             w_empty_after;
   logic             w_unused_pc_bits;

   assign w_unused_pc_bits = ^{i_redirect_pc[31:PC_W], i_redirect_pc[1:0]};

   assign w_pop  = !w_empty && bus.if_ready;
   assign w_push = (r_state == FETCH) && !i_redirect_valid && !i_halt_req
                   && (!w_full || w_pop);

   // Only consulted while halting or draining, where no push can occur.
   assign w_empty_after = i_redirect_valid || w_empty
                          || (w_count == CNT_W'(1) && w_pop);

   assign w_wr_entry.pc    = 32'(r_pc);
   assign w_wr_entry.instr = bus.imem_rdata;

   fetch_buffer #(
      .DEPTH (BUF_DEPTH),
      .CNT_W (CNT_W)
   ) u_buffer (
      .clock     (clock),
      .resetn    (resetn),
      .i_push    (w_push),
      .i_pop     (w_pop),
      .i_flush   (i_redirect_valid),
      .i_wr_data (w_wr_entry),
      .o_head    (w_head),
      .o_count   (w_count),
      .o_full    (w_full),
      .o_empty   (w_empty)
   );

   always_comb begin
      w_state_next = r_state;
      w_pc_next    = r_pc;
      case (r_state)
         IDLE, HALTED: if (i_start) w_state_next = FETCH;
         FETCH:        if (i_halt_req) w_state_next = w_empty_after ? HALTED : DRAIN;
         DRAIN:        if (w_empty_after) w_state_next = HALTED;
         default:      w_state_next = IDLE;
      endcase
      if (i_redirect_valid)
         w_pc_next = {i_redirect_pc[PC_W-1:2], 2'b00};
      else if (w_push)
         w_pc_next = r_pc + PC_W'(PC_STEP);
   end

   always_ff @(posedge clock or negedge resetn) begin
      if (!resetn) begin
         r_state <= IDLE;
         r_pc    <= RESET_PC[PC_W-1:0];
      end else begin
         r_state <= w_state_next;
         r_pc    <= w_pc_next;
      end
   end

   assign bus.imem_addr = r_pc;
   assign bus.if_valid  = !w_empty;
   assign bus.if_instr  = w_head.instr;
   assign bus.if_pc     = w_head.pc;
   assign o_busy        = (r_state == FETCH) || (r_state == DRAIN);
   assign o_state       = r_state;
endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer with an address-echo instruction memory.
module tb_fetch_sequencer;
   import fetch_pkg::*;

   logic        clock = 1'b0;
   logic        resetn;
   logic        start;
   logic        halt_req;
   logic        redirect_valid;
   logic [31:0] redirect_pc;
   logic        busy;
   logic [1:0]  state;

   int n_cmp = 0;
   int n_err = 0;

   always #5 clock = ~clock;

   fetch_sequencer_if #(.ADDR_WIDTH(6)) bus ();

   assign bus.imem_rdata = {24'hA5A5A5, bus.imem_addr[7:0]};

   fetch_sequencer #(
      .ADDR_WIDTH (6),
      .RESET_PC   (32'd0),
      .BUF_DEPTH  (2)
   ) dut (
      .clock            (clock),
      .resetn           (resetn),
      .i_start          (start),
      .i_halt_req       (halt_req),
      .i_redirect_valid (redirect_valid),
      .i_redirect_pc    (redirect_pc),
      .o_busy           (busy),
      .o_state          (state),
      .bus              (bus)
   );

   always @(posedge clock) begin
      if (resetn && bus.if_valid && bus.if_ready)
         $display("accept pc=%08h instr=%08h", bus.if_pc, bus.if_instr);
   end

   task automatic tick();
      @(posedge clock);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s: observed %08h expected %08h", tag, obs, exp);
      end
   endtask

   task automatic chk_head(input string tag, input logic [31:0] pc);
      logic [31:0] exp_instr;
      exp_instr = {24'hA5A5A5, pc[7:0]};
      chk({tag, ".valid"}, 32'(bus.if_valid), 32'd1);
      chk({tag, ".pc"}, bus.if_pc, pc);
      chk({tag, ".instr"}, bus.if_instr, exp_instr);
   endtask

   initial begin
      resetn         = 1'b0;
      start          = 1'b0;
      halt_req       = 1'b0;
      redirect_valid = 1'b0;
      redirect_pc    = 32'd0;
      bus.if_ready   = 1'b0;
      tick();
      tick();
      chk("rst.valid", 32'(bus.if_valid), 32'd0);
      chk("rst.instr", bus.if_instr, 32'd0);
      chk("rst.pc", bus.if_pc, 32'd0);
      chk("rst.busy", 32'(busy), 32'd0);
      chk("rst.state", 32'(state), 32'd0);
      chk("rst.addr", 32'(bus.imem_addr), 32'd0);

      // start -> FETCH next cycle, first valid one cycle later
      resetn       = 1'b1;
      start        = 1'b1;
      bus.if_ready = 1'b1;
      tick();
      start = 1'b0;
      chk("start.state", 32'(state), 32'd1);
      chk("start.busy", 32'(busy), 32'd1);
      chk("start.valid", 32'(bus.if_valid), 32'd0);
      tick();
      chk_head("first", 32'h00);

      // backpressure: buffer fills to two, PC parks at 8
      bus.if_ready = 1'b0;
      for (int i = 0; i < 5; i++) begin
         tick();
         chk_head("stall", 32'h00);
      end
      chk("stall.addr", 32'(bus.imem_addr), 32'h08);

      bus.if_ready = 1'b1;
      for (int k = 1; k <= 4; k++) begin
         tick();
         chk_head("stream", 32'(k * 4));
      end

      // redirect while head 0x10 is accepted; 0x14 is dropped
      redirect_valid = 1'b1;
      redirect_pc    = 32'h40;
      tick();
      redirect_valid = 1'b0;
      chk("redir.valid", 32'(bus.if_valid), 32'd0);
      chk("redir.addr", 32'(bus.imem_addr), 32'h40);
      chk("redir.state", 32'(state), 32'd1);
      tick();
      chk_head("redir.t0", 32'h40);
      tick();
      chk_head("redir.t1", 32'h44);

      // unaligned, oversize target is truncated to 0xF4; then PC wraps
      redirect_valid = 1'b1;
      redirect_pc    = 32'h1F7;
      tick();
      redirect_valid = 1'b0;
      chk("trunc.valid", 32'(bus.if_valid), 32'd0);
      chk("trunc.addr", 32'(bus.imem_addr), 32'hF4);
      tick();
      chk_head("wrap.f4", 32'hF4);
      tick();
      chk_head("wrap.f8", 32'hF8);
      tick();
      chk_head("wrap.fc", 32'hFC);
      chk("wrap.addr", 32'(bus.imem_addr), 32'h00);
      tick();
      chk_head("wrap.00", 32'h00);
      tick();
      chk_head("wrap.04", 32'h04);

      // halt with two entries buffered
      bus.if_ready = 1'b0;
      tick();
      tick();
      chk("full.addr", 32'(bus.imem_addr), 32'h0C);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("drain.state", 32'(state), 32'd2);
      chk("drain.busy", 32'(busy), 32'd1);
      chk_head("drain.h0", 32'h04);
      tick();
      chk("drain.addr", 32'(bus.imem_addr), 32'h0C);
      chk("drain.state2", 32'(state), 32'd2);
      bus.if_ready = 1'b1;
      tick();
      chk_head("drain.h1", 32'h08);
      chk("drain.state3", 32'(state), 32'd2);
      tick();
      chk("halted.state", 32'(state), 32'd3);
      chk("halted.busy", 32'(busy), 32'd0);
      chk("halted.valid", 32'(bus.if_valid), 32'd0);
      chk("halted.pc_hold", bus.if_pc, 32'h08);
      halt_req = 1'b1;
      tick();
      halt_req = 1'b0;
      chk("halted.ignore", 32'(state), 32'd3);

      // restart continues at the next sequential PC
      start = 1'b1;
      tick();
      start = 1'b0;
      chk("restart.state", 32'(state), 32'd1);
      chk("restart.valid", 32'(bus.if_valid), 32'd0);
      tick();
      chk_head("restart.0c", 32'h0C);
      tick();
      chk_head("restart.10", 32'h10);

      // asynchronous reset in the middle of a stream
      resetn = 1'b0;
      #1;
      chk("arst.valid", 32'(bus.if_valid), 32'd0);
      chk("arst.addr", 32'(bus.imem_addr), 32'd0);
      chk("arst.state", 32'(state), 32'd0);
      chk("arst.pc", bus.if_pc, 32'd0);
      tick();
      resetn = 1'b1;
      start  = 1'b1;
      tick();
      start = 1'b0;
      tick();
      chk_head("rerun.00", 32'h00);
      tick();
      chk_head("rerun.04", 32'h04);

      // halt and redirect together go straight to HALTED
      halt_req       = 1'b1;
      redirect_valid = 1'b1;
      redirect_pc    = 32'h80;
      tick();
      halt_req       = 1'b0;
      redirect_valid = 1'b0;
      chk("hr.state", 32'(state), 32'd3);
      chk("hr.valid", 32'(bus.if_valid), 32'd0);
      chk("hr.addr", 32'(bus.imem_addr), 32'h80);
      chk("hr.busy", 32'(busy), 32'd0);

      // redirect while halted only reloads the PC
      redirect_valid = 1'b1;
      redirect_pc    = 32'h24;
      tick();
      redirect_valid = 1'b0;
      tick();
      chk("hredir.addr", 32'(bus.imem_addr), 32'h24);
      chk("hredir.state", 32'(state), 32'd3);
      chk("hredir.valid", 32'(bus.if_valid), 32'd0);

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
